fifo_wr_ctrl: RTL and testbench
===============================

// Module: fifo_wr_ctrl
// PURPOSE
//  Write-side controller for the dual-clock FIFO, sitting on the write clock domain.
//  It waits until the FIFO reports empty, then fills it with one burst of incrementing data words.
//  Each burst is exactly DEPTH words, unless the FIFO signals full early.
//  It pairs with the read-side controller, which drains the FIFO once it is full, so
//  the two controllers form a continuous fill/drain loop with a data pattern the reader can check.
// PARAMETERS
//  DATA_W     8    width of the write data word
//  DEPTH      256  FIFO depth = words per burst (>=2); CNT_W = $clog2(DEPTH)
//  START_VAL  0    first data value after reset
// PORTS
//  clk         in   1       write-side clock
//  rst_n       in   1       asynchronous reset, active low
//  enable      in   1       allow new bursts to start (level)
//  wrempty     in   1       FIFO empty flag, write-clock domain
//  wrfull      in   1       FIFO full flag, write-clock domain
//  wrreq       out  1       write request; the FIFO writes data on every clk edge where wrreq=1
//  data        out  DATA_W  write data, valid whenever wrreq=1
//  burst_done  out  1       one-cycle pulse after the last word of a burst
//  burst_cnt   out  16      number of completed bursts, wraps modulo 2^16
//  err_ovf     out  1       sticky: wrreq=1 and wrfull=1 at the same clk edge
// BEHAVIOUR
//  Reset (asynchronous, takes effect immediately, even mid-burst):
//   - state=IDLE, wrreq=0, data=START_VAL, wr_cnt=0
//   - burst_done=0, burst_cnt=0, err_ovf=0
//  All outputs are registered; there is no combinational path from inputs to outputs.
//  States:
//   IDLE: wrreq=0. If enable=1, go to WAIT_EMPTY on the next edge.
//   WAIT_EMPTY: wrreq=0.
//    - If enable=0, go to IDLE.
//    - Else if wrempty=1, set wrreq<=1, wr_cnt<=0, and go to FILL.
//    - So the first word is presented 1 cycle after wrempty is sampled high.
//   FILL: every edge with wrreq=1 counts as one accepted word.
//    - On each such edge: data<=data+1 (wraps modulo 2^DATA_W) and wr_cnt<=wr_cnt+1.
//    - If wr_cnt==DEPTH-1 or wrfull=1: wrreq<=0 and go to DONE.
//    - Otherwise wrreq stays 1.
//    - A full burst is therefore DEPTH consecutive cycles with wrreq=1.
//   DONE: burst_done=1 for exactly this one cycle, and burst_cnt increments.
//    - Next state is WAIT_EMPTY if enable=1, else IDLE.
//  Further rules:
//   - data is NOT reset between bursts. Burst n+1 continues from the last value of burst n plus 1.
//   - Deasserting enable during FILL does not shorten the burst. The burst completes, then
//     the controller goes to IDLE. Partial bursts occur only through wrfull or reset.
//   - An early stop on wrfull always sets err_ovf, because wrreq was already high at that edge.
//     The word at that edge is counted as written.
//   - wrempty is ignored outside WAIT_EMPTY.
//   - wrfull is ignored outside FILL, except for the err_ovf check.
//   - err_ovf is cleared only by reset.
//   - A simultaneous wrempty=1 and wrfull=1 in WAIT_EMPTY starts a burst, which then
//     stops at the first FILL edge with err_ovf=1.
// TESTING
//  T1 reset: assert rst_n=0 mid-FILL -> wrreq, burst_done, burst_cnt, err_ovf are 0 and
//     data=START_VAL in the same cycle, with no clock edge needed.
//  T2 DEPTH=8, START_VAL=0: enable=1, wrempty=1 ->
//     wrreq high for 8 cycles with data 0..7, then burst_done high for 1 cycle, burst_cnt=1.
//  T3 keep wrempty=0 for 20 cycles after T2 -> wrreq stays 0.
//     Then pulse wrempty for 1 cycle -> second burst with data 8..15, burst_cnt=2.
//  T4 DEPTH=8: raise wrfull on the 5th write cycle -> exactly 5 words (0..4) written,
//     wrreq low on the next cycle, err_ovf=1 and stays 1 through later clean bursts.
//  T5 DATA_W=3, DEPTH=4, two bursts -> data 0,1,2,3 then 4,5,6,7; a third burst shows 0,1,2,3 (wrap).
//  T6 drop enable on the 3rd FILL cycle of an 8-word burst -> all 8 words written,
//     burst_done pulses, state returns to IDLE, and no new burst starts while wrempty=1.

Source files
------------

// File: rtl/fifo_wr_ctrl.sv
// Write-side FIFO controller: waits for empty, then writes one burst of DEPTH
// incrementing words (cut short by wrfull), and counts completed bursts.
module fifo_wr_ctrl #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned START_VAL = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              wrempty,
  input  logic              wrfull,
  output logic              wrreq,
  output logic [DATA_W-1:0] data,
  output logic              burst_done,
  output logic [15:0]       burst_cnt,
  output logic              err_ovf
);

  localparam int unsigned CNT_W = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_WAIT_EMPTY = 2'd1;
  localparam logic [1:0] S_FILL       = 2'd2;
  localparam logic [1:0] S_DONE       = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              wrreq_q, wrreq_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic              burst_done_q, burst_done_d;
  logic [15:0]       burst_cnt_q, burst_cnt_d;
  logic              err_ovf_q, err_ovf_d;

  always_comb begin
    state_d      = state_q;
    wrreq_d      = wrreq_q;
    data_d       = data_q;
    wr_cnt_d     = wr_cnt_q;
    burst_done_d = 1'b0;
    burst_cnt_d  = burst_cnt_q;
    // Any write into a full FIFO is recorded, whatever the state.
    err_ovf_d    = err_ovf_q | (wrreq_q & wrfull);

    unique case (state_q)
      S_IDLE: begin
        wrreq_d = 1'b0;
        if (enable) state_d = S_WAIT_EMPTY;
      end
      S_WAIT_EMPTY: begin
        wrreq_d = 1'b0;
        if (!enable) begin
          state_d = S_IDLE;
        end else if (wrempty) begin
          wrreq_d  = 1'b1;
          wr_cnt_d = '0;
          state_d  = S_FILL;
        end
      end
      S_FILL: begin
        if (wrreq_q) begin
          data_d   = data_q + DATA_W'(1);
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
          // The word on this edge is accepted even when wrfull stops the burst.
          if (wr_cnt_q == CNT_W'(DEPTH - 1) || wrfull) begin
            wrreq_d      = 1'b0;
            burst_done_d = 1'b1;
            burst_cnt_d  = burst_cnt_q + 16'd1;
            state_d      = S_DONE;
          end
        end
      end
      S_DONE: begin
        wrreq_d = 1'b0;
        state_d = enable ? S_WAIT_EMPTY : S_IDLE;
      end
      default: begin
        wrreq_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wrreq_q      <= 1'b0;
      data_q       <= DATA_W'(START_VAL);
      wr_cnt_q     <= '0;
      burst_done_q <= 1'b0;
      burst_cnt_q  <= 16'd0;
      err_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wrreq_q      <= wrreq_d;
      data_q       <= data_d;
      wr_cnt_q     <= wr_cnt_d;
      burst_done_q <= burst_done_d;
      burst_cnt_q  <= burst_cnt_d;
      err_ovf_q    <= err_ovf_d;
    end
  end

  assign wrreq      = wrreq_q;
  assign data       = data_q;
  assign burst_done = burst_done_q;
  assign burst_cnt  = burst_cnt_q;
  assign err_ovf    = err_ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: two instances (8-bit/8-deep and 3-bit/4-deep) with
// expected write words and burst counts queued by stimulus and popped by monitors.
module tb_fifo_wr_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       en_a = 1'b0, empty_a = 1'b0, full_a = 1'b0;
  logic       wrreq_a, done_a, ovf_a;
  logic [7:0] data_a;
  logic [15:0] cnt_a;

  logic       en_b = 1'b0, empty_b = 1'b0, full_b = 1'b0;
  logic       wrreq_b, done_b, ovf_b;
  logic [2:0] data_b;
  logic [15:0] cnt_b;

  fifo_wr_ctrl #(.DATA_W(8), .DEPTH(8), .START_VAL(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .wrempty(empty_a), .wrfull(full_a),
    .wrreq(wrreq_a), .data(data_a), .burst_done(done_a), .burst_cnt(cnt_a), .err_ovf(ovf_a)
  );

  fifo_wr_ctrl #(.DATA_W(3), .DEPTH(4), .START_VAL(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .wrempty(empty_b), .wrfull(full_b),
    .wrreq(wrreq_b), .data(data_b), .burst_done(done_b), .burst_cnt(cnt_b), .err_ovf(ovf_b)
  );

  int errors = 0;
  int checks = 0;
  int exp_data_a[$], exp_cnt_a[$], exp_data_b[$], exp_cnt_b[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic pop_check(input string name, inout int q[$], input int act);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected output %0d, expected nothing", name, act);
    end else begin
      check(name, act, q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (wrreq_a) pop_check("a_data", exp_data_a, int'(data_a));
      if (done_a)  pop_check("a_burst_cnt", exp_cnt_a, int'(cnt_a));
      if (wrreq_b) pop_check("b_data", exp_data_b, int'(data_b));
      if (done_b)  pop_check("b_burst_cnt", exp_cnt_b, int'(cnt_b));
    end
  end

  task automatic push_a(input int first, input int n, input int cnt);
    for (int i = 0; i < n; i++) exp_data_a.push_back((first + i) % 256);
    if (cnt >= 0) exp_cnt_a.push_back(cnt);
  endtask

  task automatic push_b(input int first, input int n, input int cnt);
    for (int i = 0; i < n; i++) exp_data_b.push_back((first + i) % 8);
    exp_cnt_b.push_back(cnt);
  endtask

  // Returns at the negedge of the first write cycle; FIFO reports empty until then.
  task automatic start_a(input string name);
    bit seen = 0;
    en_a = 1'b1;
    empty_a = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (wrreq_a) seen = 1;
    end
    empty_a = 1'b0;
    if (!seen) check({name, "_start_timeout"}, 0, 1);
  endtask

  task automatic wait_done_a(input string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done_a) seen = 1;
    end
    if (!seen) check({name, "_done_timeout"}, 0, 1);
  endtask

  task automatic burst_b(input string name);
    bit seen = 0;
    en_b = 1'b1;
    empty_b = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (wrreq_b) seen = 1;
    end
    empty_b = 1'b0;
    if (!seen) check({name, "_start_timeout"}, 0, 1);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done_b) seen = 1;
    end
    if (!seen) check({name, "_done_timeout"}, 0, 1);
  endtask

  int n_wr;

  initial begin
    // Reset state, held through a few edges.
    repeat (3) @(negedge clk);
    check("rst_wrreq", int'(wrreq_a), 0);
    check("rst_data", int'(data_a), 0);
    check("rst_burst_cnt", int'(cnt_a), 0);
    check("rst_err_ovf", int'(ovf_a), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // First full burst: words 0..7, then burst_cnt=1.
    push_a(0, 8, 1);
    start_a("t2");
    wait_done_a("t2");

    // No empty indication: no writes for 20 cycles.
    n_wr = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wrreq_a) n_wr++;
    end
    check("t3_idle_writes", n_wr, 0);

    // One-cycle empty pulse starts the next burst, data continues from 8.
    push_a(8, 8, 2);
    empty_a = 1'b1;
    @(negedge clk);
    empty_a = 1'b0;
    wait_done_a("t3");

    // wrfull on the 5th write cycle: 5 words accepted, overflow flagged.
    push_a(16, 5, 3);
    start_a("t4");
    repeat (4) @(negedge clk);
    full_a = 1'b1;
    @(negedge clk);
    full_a = 1'b0;
    check("t4_wrreq_after_full", int'(wrreq_a), 0);
    check("t4_burst_done", int'(done_a), 1);
    check("t4_err_ovf", int'(ovf_a), 1);

    // Clean burst afterwards keeps err_ovf sticky.
    push_a(21, 8, 4);
    start_a("t4b");
    wait_done_a("t4b");
    check("t4_err_ovf_sticky", int'(ovf_a), 1);

    // enable dropped on the 3rd fill cycle: burst still completes, then idle.
    push_a(29, 8, 5);
    start_a("t6");
    repeat (2) @(negedge clk);
    en_a = 1'b0;
    wait_done_a("t6");
    empty_a = 1'b1;
    n_wr = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wrreq_a) n_wr++;
    end
    empty_a = 1'b0;
    check("t6_no_restart", n_wr, 0);

    // Asynchronous reset in the middle of a burst.
    push_a(37, 3, -1);
    start_a("t1");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t1_wrreq", int'(wrreq_a), 0);
    check("t1_data", int'(data_a), 0);
    check("t1_burst_done", int'(done_a), 0);
    check("t1_burst_cnt", int'(cnt_a), 0);
    check("t1_err_ovf", int'(ovf_a), 0);
    en_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 3-bit data, 4-deep: 0..3, 4..7, then wrap to 0..3.
    push_b(0, 4, 1);
    push_b(4, 4, 2);
    push_b(8, 4, 3);
    burst_b("t5_1");
    burst_b("t5_2");
    burst_b("t5_3");
    check("t5_err_ovf", int'(ovf_b), 0);
    en_b = 1'b0;
    repeat (3) @(negedge clk);

    check("a_data_left", exp_data_a.size(), 0);
    check("a_cnt_left", exp_cnt_a.size(), 0);
    check("b_data_left", exp_data_b.size(), 0);
    check("b_cnt_left", exp_cnt_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
